prog_fetch_ctrl: RTL and testbench

Initiator-side controller for the 16 x 8 program memory (`prog_mem`). It drives the memory's write/read port in two modes:
- **LOAD** streams a program into memory from address 0.
- **FETCH** reads instructions sequentially from a start address and hands them to the decoder over a valid/ready handshake, with jump redirect and halt detection.

It sits between the program loader / instruction decoder and `prog_mem`.

---
 rtl/prog_pkg.sv | 8 +
 rtl/prog_mem.sv | 21 ++
 rtl/prog_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_prog_fetch_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// prog_pkg: shared state encoding, halt opcode and default sizes for the program memory controller
package prog_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 16;
  localparam logic [7:0] HALT_OP = 8'hFF;
  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, HOLD, HALT} state_t;
endpackage

// File: rtl/prog_mem.sv
// prog_mem: single-port program memory; registered read one cycle after rd_enable, write on wr_enable
module prog_mem
  import prog_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              wr_enable,
  input  logic              rd_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (wr_enable) mem[addr] <= wr_data;
    if (rd_enable) rd_data <= mem[addr];
  end
endmodule

// File: rtl/prog_fetch_ctrl.sv
// prog_fetch_ctrl: loads a program into prog_mem and fetches instructions to the decoder over valid/ready with jump and halt
module prog_fetch_ctrl
  import prog_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              fetch_start,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              wr_enable,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] acc_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, addr_n, ipc_n;
  logic [ADDR_W:0] wptr, wptr_n;
  logic [DATA_W-1:0] acc_n, instr_n;
  logic fin, fin_n, lr_n, iv_n, wr_n, rd_n, done_n, err_n, jmp, full;
  assign jmp = jump_valid && (state == RD_REQ || state == RD_WAIT || state == HOLD);
  assign full = wptr == (ADDR_W + 1)'(DEPTH);
  always_comb begin
    state_n = state;
    pc_n = pc;
    wptr_n = wptr;
    fin_n = 1'b0;
    lr_n = 1'b0;
    iv_n = 1'b0;
    wr_n = 1'b0;
    rd_n = 1'b0;
    addr_n = addr;
    acc_n = acc_data;
    instr_n = instr;
    ipc_n = instr_pc;
    done_n = done;
    err_n = err;
    case (state)
      IDLE, HALT: begin
        if (load_start) begin
          err_n = 1'b0;
          done_n = 1'b0;
          wptr_n = '0;
          lr_n = 1'b1;
          state_n = LOAD;
        end else if (fetch_start) begin
          pc_n = fetch_addr;
          done_n = 1'b0;
          rd_n = 1'b1;
          addr_n = fetch_addr;
          state_n = RD_REQ;
        end
      end
      LOAD: begin
        if (fin) state_n = IDLE;
        else begin
          lr_n = 1'b1;
          if (load_valid && load_ready) begin
            if (full) err_n = 1'b1;
            else begin
              wr_n = 1'b1;
              addr_n = wptr[ADDR_W-1:0];
              acc_n = load_data;
              wptr_n = wptr + 1'b1;
            end
            // a dropped last byte has no write cycle to wait for
            if (load_last) begin
              lr_n = 1'b0;
              fin_n = !full;
              state_n = full ? IDLE : LOAD;
            end
          end
        end
      end
      RD_REQ: state_n = RD_WAIT;
      RD_WAIT: begin
        instr_n = rd_data;
        ipc_n = pc;
        iv_n = 1'b1;
        state_n = HOLD;
      end
      HOLD: begin
        iv_n = !(instr_valid && instr_ready);
        if (instr_valid && instr_ready) begin
          if (instr == DATA_W'(HALT_OP)) begin
            done_n = 1'b1;
            state_n = HALT;
          end else begin
            pc_n = pc + 1'b1;
            rd_n = 1'b1;
            addr_n = pc + 1'b1;
            state_n = RD_REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // a redirect overrides whatever the fetch pipeline was doing, including stale read data
    if (jmp) begin
      pc_n = jump_addr;
      rd_n = 1'b1;
      addr_n = jump_addr;
      iv_n = 1'b0;
      instr_n = instr;
      ipc_n = instr_pc;
      done_n = done;
      state_n = RD_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
      pc <= '0;
      wptr <= '0;
      fin <= 1'b0;
      load_ready <= 1'b0;
      instr_valid <= 1'b0;
      instr <= '0;
      instr_pc <= '0;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      addr <= '0;
      acc_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      wptr <= wptr_n;
      fin <= fin_n;
      load_ready <= lr_n;
      instr_valid <= iv_n;
      instr <= instr_n;
      instr_pc <= ipc_n;
      wr_enable <= wr_n;
      rd_enable <= rd_n;
      addr <= addr_n;
      acc_data <= acc_n;
      busy <= state_n != IDLE && state_n != HALT;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// tb_prog_fetch_ctrl: directed self-checking bench for prog_fetch_ctrl with prog_mem as responder
module tb_prog_fetch_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, load_start, load_valid, load_last, load_ready, fetch_start, jump_valid;
  logic instr_valid, instr_ready, wr_enable, rd_enable, busy, done, err;
  logic [7:0] load_data, instr, acc_data, rd_data;
  logic [3:0] fetch_addr, jump_addr, instr_pc, addr;
  int tests = 0, fails = 0, both_cnt = 0;
  logic [3:0] wr_addr [$];
  logic [7:0] wr_dat [$];
  logic jump_win = 1'b0, saw_pc0 = 1'b0;
  prog_fetch_ctrl dut (
    .clk(clk), .rstn(rstn), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr), .jump_valid(jump_valid),
    .jump_addr(jump_addr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .wr_enable(wr_enable), .rd_enable(rd_enable),
    .addr(addr), .acc_data(acc_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );
  prog_mem u_mem (
    .clk(clk), .wr_enable(wr_enable), .rd_enable(rd_enable), .addr(addr),
    .wr_data(acc_data), .rd_data(rd_data)
  );
  always @(negedge clk) begin
    if (wr_enable) begin
      wr_addr.push_back(addr);
      wr_dat.push_back(acc_data);
    end
    if (wr_enable && rd_enable) both_cnt++;
    if (jump_win && instr_valid && instr_pc == 4'd0) saw_pc0 = 1'b1;
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [30:0] outs();
    return {load_ready, instr_valid, instr, instr_pc, wr_enable, rd_enable, addr, acc_data, busy, done, err};
  endfunction
  initial begin
    int bad;
    rstn = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    fetch_start = 1'b0; fetch_addr = 4'd0; jump_valid = 1'b0; jump_addr = 4'd0; instr_ready = 1'b0;
    step(2);
    chk("reset_outs", 32'(outs()), 32'd0);
    rstn = 1'b0;
    step();
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("ld_ready", {load_ready, busy}, {1'b1, 1'b1});
    wr_addr.delete(); wr_dat.delete();
    load_valid = 1'b1; load_data = 8'h59; step();
    chk("ld_w0", {wr_enable, addr, acc_data}, {1'b1, 4'd0, 8'd89});
    load_data = 8'h2E; step();
    chk("ld_w1", {wr_enable, addr, acc_data}, {1'b1, 4'd1, 8'd46});
    load_data = 8'hFF; load_last = 1'b1; step();
    chk("ld_w2", {wr_enable, addr, acc_data}, {1'b1, 4'd2, 8'd255});
    chk("ld_last_ready", {load_ready, busy}, {1'b0, 1'b1});
    load_valid = 1'b0; load_last = 1'b0; step();
    chk("ld_end", {wr_enable, busy, err}, 3'b000);
    chk("ld_wcnt", wr_addr.size(), 3);
    fetch_addr = 4'd0; fetch_start = 1'b1; step(); fetch_start = 1'b0;
    chk("f_req0", {rd_enable, addr, instr_valid}, {1'b1, 4'd0, 1'b0});
    step();
    chk("f_wait0", {rd_enable, instr_valid}, 2'b00);
    step();
    chk("f_hold0", {instr_valid, instr, instr_pc}, {1'b1, 8'd89, 4'd0});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {instr_valid, instr, instr_pc, rd_enable}, {1'b1, 8'd89, 4'd0, 1'b0});
    end
    instr_ready = 1'b1; step();
    chk("f_req1", {rd_enable, addr, instr_valid}, {1'b1, 4'd1, 1'b0});
    step(2);
    chk("f_hold1", {instr_valid, instr, instr_pc}, {1'b1, 8'd46, 4'd1});
    step();
    chk("f_req2", {rd_enable, addr}, {1'b1, 4'd2});
    step(2);
    chk("f_hold2", {instr_valid, instr, instr_pc}, {1'b1, 8'd255, 4'd2});
    step();
    chk("f_halt", {done, busy, instr_valid}, 3'b100);
    instr_ready = 1'b0;
    load_start = 1'b1; step(); load_start = 1'b0;
    chk("ovf_start", {done, load_ready}, 2'b01);
    wr_addr.delete(); wr_dat.delete();
    for (int i = 0; i < 17; i++) begin
      load_valid = 1'b1;
      load_data = (i == 0) ? 8'hFF : (i == 15) ? 8'h17 : (i == 16) ? 8'hAA : 8'(8'h20 + i);
      load_last = (i == 16);
      step();
      if (i == 15) chk("ovf_err_pre", {err, wr_enable}, 2'b01);
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("ovf_err", {err, busy, wr_enable}, 3'b100);
    step();
    chk("ovf_wcnt", wr_addr.size(), 16);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) if (wr_addr[i] != 4'(i)) bad++;
    chk("ovf_addr_seq", bad, 0);
    chk("ovf_mem0", u_mem.mem[0], 8'hFF);
    fetch_addr = 4'd0; fetch_start = 1'b1; jump_win = 1'b1; step(); fetch_start = 1'b0;
    chk("j_req0", {rd_enable, addr}, {1'b1, 4'd0});
    step();
    jump_valid = 1'b1; jump_addr = 4'd5; step(); jump_valid = 1'b0;
    chk("j_req5", {rd_enable, addr, instr_valid}, {1'b1, 4'd5, 1'b0});
    step(2);
    chk("j_hold5", {instr_valid, instr, instr_pc}, {1'b1, 8'h25, 4'd5});
    jump_win = 1'b0;
    chk("j_no_pc0", saw_pc0, 1'b0);
    jump_valid = 1'b1; jump_addr = 4'd0; step(); jump_valid = 1'b0;
    chk("j_from_hold", {rd_enable, addr, instr_valid}, {1'b1, 4'd0, 1'b0});
    step(2);
    chk("j_hold0", {instr_valid, instr, instr_pc}, {1'b1, 8'hFF, 4'd0});
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    chk("j_done", {done, busy}, 2'b10);
    fetch_addr = 4'd15; fetch_start = 1'b1; step(); fetch_start = 1'b0;
    chk("w_req15", {rd_enable, addr, done}, {1'b1, 4'd15, 1'b0});
    step(2);
    chk("w_hold15", {instr_valid, instr, instr_pc}, {1'b1, 8'h17, 4'd15});
    instr_ready = 1'b1; step();
    chk("w_req0", {rd_enable, addr}, {1'b1, 4'd0});
    step(2);
    chk("w_hold0", {instr_valid, instr, instr_pc}, {1'b1, 8'hFF, 4'd0});
    step(); instr_ready = 1'b0;
    chk("w_done", {done, busy}, 2'b10);
    load_start = 1'b1; step(); load_start = 1'b0;
    wr_addr.delete(); wr_dat.delete();
    load_valid = 1'b1; load_data = 8'hFF; step();
    load_data = 8'h33; step();
    load_data = 8'h44; rstn = 1'b1; step();
    chk("rst_outs", 32'(outs()), 32'd0);
    load_data = 8'h55; step();
    rstn = 1'b0; step(3);
    load_valid = 1'b0;
    chk("rst_wcnt", wr_addr.size(), 2);
    chk("rst_outs_after", 32'(outs()), 32'd0);
    fetch_addr = 4'd0; fetch_start = 1'b1; step(); fetch_start = 1'b0;
    chk("rst_freq", {rd_enable, addr}, {1'b1, 4'd0});
    step(2);
    chk("rst_fhold", {instr_valid, instr, instr_pc}, {1'b1, 8'hFF, 4'd0});
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    chk("rst_fdone", {done, busy}, 2'b10);
    chk("no_wr_rd_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
